sm_ctrl_fsm: RTL and testbench

- Multicycle control FSM, second generation, for the 16-bit simple RISC CPU. It drives the datapath, the PC/IR/address registers and the memory command bus.
- Adds to the first generation: a memory-ready handshake with a parametrised timeout, conditional and unconditional branches, and branch-with-link/return.
- Sits between the instruction decoder (opcode, op, cond fields) and the datapath plus memory interface.

---
 rtl/sm_ctrl_fsm.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sm_ctrl_fsm.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_ctrl_fsm.sv
// sm_ctrl_fsm: second-generation multicycle control FSM for the 16-bit simple RISC CPU.
// Drives datapath enables/selects, PC/IR/address registers and the memory command bus.
// Memory requests wait on mem_rdy with a WAIT_MAX cycle timeout (0 = wait forever).
// Optional feature: define SM_CTRL_PERF_EN to add the o_instret retired-fetch counter.
module sm_ctrl_fsm #(
    parameter int WAIT_MAX = 15
`ifdef SM_CTRL_PERF_EN
    ,parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_opcode,
    input  logic [1:0] i_op,
    input  logic [2:0] i_cond,
    input  logic       i_Z,
    input  logic       i_N,
    input  logic       i_V,
    input  logic       i_mem_rdy,
    output logic       o_loada,
    output logic       o_loadb,
    output logic       o_loadc,
    output logic       o_loads,
    output logic       o_asel,
    output logic       o_bsel,
    output logic       o_write,
    output logic [3:0] o_nsel,
    output logic [3:0] o_vsel,
    output logic       o_load_ir,
    output logic       o_load_pc,
    output logic       o_reset_pc,
    output logic       o_load_addr,
    output logic       o_addr_sel,
    output logic [1:0] o_pc_sel,
    output logic [1:0] o_mem_cmd,
    output logic       o_halted,
    output logic       o_fault
`ifdef SM_CTRL_PERF_EN
    ,output logic [CNT_W-1:0] o_instret
`endif
);

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = (WAIT_MAX == 0) ? '0 : WCW'(WAIT_MAX - 1);

    typedef enum logic [4:0] {
        S_RST, S_IF_REQ, S_IF_LD, S_UPC, S_DEC,
        S_MOVI, S_GETA, S_GETB, S_ALU, S_WREG,
        S_MOV_B, S_MOV_C,
        S_LD_A, S_LD_ADD, S_LD_ADDR, S_LD_REQ, S_LD_WB,
        S_ST_A, S_ST_ADD, S_ST_ADDR, S_ST_C, S_ST_REQ,
        S_BR, S_BL, S_BX_B, S_BX_C, S_BX_PC, S_BLX,
        S_HALT, S_FAULT
    } state_t;

    typedef struct packed {
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic [3:0] nsel;
        logic [3:0] vsel;
        logic       loadIr;
        logic       loadPc;
        logic       resetPc;
        logic       loadAddr;
        logic       addrSel;
        logic [1:0] pcSel;
        logic [1:0] memCmd;
        logic       halted;
        logic       fault;
    } ctrl_t;

    localparam logic [3:0] NSEL_R7 = 4'b1000;
    localparam logic [3:0] NSEL_RN = 4'b0100;
    localparam logic [3:0] NSEL_RD = 4'b0010;
    localparam logic [3:0] NSEL_RM = 4'b0001;
    localparam logic [3:0] VSEL_C  = 4'b0001;
    localparam logic [3:0] VSEL_PC = 4'b0010;
    localparam logic [3:0] VSEL_IM = 4'b0100;
    localparam logic [3:0] VSEL_MD = 4'b1000;
    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_REL  = 2'b01;
    localparam logic [1:0] PC_DP   = 2'b10;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;

    // Moore output word for each state; a taken branch only matters in S_BR
    function automatic ctrl_t stateOut(input state_t s, input logic taken);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST:     begin c.resetPc = 1'b1; c.loadPc = 1'b1; end
            S_IF_REQ:  begin c.memCmd = CMD_RD; c.addrSel = 1'b1; end
            S_IF_LD:   begin c.loadIr = 1'b1; c.memCmd = CMD_RD; c.addrSel = 1'b1; end
            S_UPC:     begin c.loadPc = 1'b1; c.pcSel = PC_INC; end
            S_MOVI:    begin c.nsel = NSEL_RN; c.vsel = VSEL_IM; c.write = 1'b1; end
            S_GETA,
            S_LD_A,
            S_ST_A:    begin c.nsel = NSEL_RN; c.loada = 1'b1; end
            S_GETB,
            S_MOV_B:   begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
            S_ALU:     begin c.loadc = 1'b1; c.loads = 1'b1; end
            S_WREG:    begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
            S_MOV_C,
            S_ST_C,
            S_BX_C:    begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_LD_ADD,
            S_ST_ADD:  begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LD_ADDR: begin c.loadAddr = 1'b1; end
            S_LD_REQ:  begin c.memCmd = CMD_RD; end
            S_LD_WB:   begin
                c.memCmd = CMD_RD;
                c.nsel   = NSEL_RD;
                c.vsel   = VSEL_MD;
                c.write  = 1'b1;
            end
            S_ST_ADDR: begin c.loadAddr = 1'b1; c.nsel = NSEL_RD; c.loadb = 1'b1; end
            S_ST_REQ:  begin c.memCmd = CMD_WR; end
            S_BR:      begin
                c.loadPc = taken;
                c.pcSel  = taken ? PC_REL : PC_INC;
            end
            S_BL:      begin
                c.nsel   = NSEL_R7;
                c.vsel   = VSEL_PC;
                c.write  = 1'b1;
                c.loadPc = 1'b1;
                c.pcSel  = PC_REL;
            end
            S_BX_B:    begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
            S_BX_PC:   begin c.loadPc = 1'b1; c.pcSel = PC_DP; end
            S_BLX:     begin c.nsel = NSEL_R7; c.vsel = VSEL_PC; c.write = 1'b1; end
            S_HALT:    begin c.halted = 1'b1; end
            S_FAULT:   begin c.fault = 1'b1; end
            default:   ;
        endcase
        return c;
    endfunction

    state_t         r_state;
    ctrl_t          r_ctrl;
    logic [WCW-1:0] r_waitCnt;

    state_t         w_next;
    logic           w_condTrue;
    logic           w_condValid;
    logic           w_inReq;
    logic           w_timeout;

    assign w_inReq     = (r_state == S_IF_REQ) || (r_state == S_LD_REQ) || (r_state == S_ST_REQ);
    assign w_timeout   = (WAIT_MAX != 0) && (r_waitCnt == WAIT_LAST);
    assign w_condValid = (i_cond <= 3'd4);

    // Branch condition evaluation from the status flags
    always_comb begin
        w_condTrue = 1'b0;
        case (i_cond)
            3'b000:  w_condTrue = 1'b1;
            3'b001:  w_condTrue = i_Z;
            3'b010:  w_condTrue = ~i_Z;
            3'b011:  w_condTrue = i_N ^ i_V;
            3'b100:  w_condTrue = (i_N ^ i_V) | i_Z;
            default: w_condTrue = 1'b0;
        endcase
    end

    // Next-state selection, including decode and the memory wait/timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:     w_next = S_IF_REQ;
            S_IF_REQ:  begin
                if (i_mem_rdy)      w_next = S_IF_LD;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_IF_LD:   w_next = S_UPC;
            S_UPC:     w_next = S_DEC;
            S_DEC:     begin
                casez ({i_opcode, i_op})
                    5'b11010: w_next = S_MOVI;
                    5'b11000: w_next = S_MOV_B;
                    5'b101??: w_next = S_GETA;
                    5'b01100: w_next = S_LD_A;
                    5'b10000: w_next = S_ST_A;
                    5'b00100: w_next = S_BR;
                    5'b01011: w_next = S_BL;
                    5'b01000: w_next = S_BX_B;
                    5'b01010: w_next = S_BLX;
                    5'b111??: w_next = S_HALT;
                    default:  w_next = S_FAULT;
                endcase
            end
            S_MOVI:    w_next = S_IF_REQ;
            S_GETA:    w_next = S_GETB;
            S_GETB:    w_next = S_ALU;
            S_ALU:     w_next = (i_op == 2'b01) ? S_IF_REQ : S_WREG;
            S_WREG:    w_next = S_IF_REQ;
            S_MOV_B:   w_next = S_MOV_C;
            S_MOV_C:   w_next = S_WREG;
            S_LD_A:    w_next = S_LD_ADD;
            S_LD_ADD:  w_next = S_LD_ADDR;
            S_LD_ADDR: w_next = S_LD_REQ;
            S_LD_REQ:  begin
                if (i_mem_rdy)      w_next = S_LD_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_LD_WB:   w_next = S_IF_REQ;
            S_ST_A:    w_next = S_ST_ADD;
            S_ST_ADD:  w_next = S_ST_ADDR;
            S_ST_ADDR: w_next = S_ST_C;
            S_ST_C:    w_next = S_ST_REQ;
            S_ST_REQ:  begin
                if (i_mem_rdy)      w_next = S_IF_REQ;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_BR:      w_next = w_condValid ? S_IF_REQ : S_FAULT;
            S_BL:      w_next = S_IF_REQ;
            S_BLX:     w_next = S_BX_B;
            S_BX_B:    w_next = S_BX_C;
            S_BX_C:    w_next = S_BX_PC;
            S_BX_PC:   w_next = S_IF_REQ;
            S_HALT:    w_next = S_HALT;
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_FAULT;
        endcase
    end

    // State, registered Moore outputs and the memory wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RST;
            r_ctrl    <= stateOut(S_RST, 1'b0);
            r_waitCnt <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= stateOut(w_next, w_condTrue);
            if (w_inReq && !i_mem_rdy && (w_next == r_state))
                r_waitCnt <= r_waitCnt + WCW'(1);
            else
                r_waitCnt <= '0;
        end
    end

    assign o_loada     = r_ctrl.loada;
    assign o_loadb     = r_ctrl.loadb;
    assign o_loadc     = r_ctrl.loadc;
    assign o_loads     = r_ctrl.loads;
    assign o_asel      = r_ctrl.asel;
    assign o_bsel      = r_ctrl.bsel;
    assign o_write     = r_ctrl.write;
    assign o_nsel      = r_ctrl.nsel;
    assign o_vsel      = r_ctrl.vsel;
    assign o_load_ir   = r_ctrl.loadIr;
    assign o_load_pc   = r_ctrl.loadPc;
    assign o_reset_pc  = r_ctrl.resetPc;
    assign o_load_addr = r_ctrl.loadAddr;
    assign o_addr_sel  = r_ctrl.addrSel;
    assign o_pc_sel    = r_ctrl.pcSel;
    assign o_mem_cmd   = r_ctrl.memCmd;
    assign o_halted    = r_ctrl.halted;
    assign o_fault     = r_ctrl.fault;

`ifdef SM_CTRL_PERF_EN
    logic [CNT_W-1:0] r_instret;

    // Count one instruction each time the PC is advanced past a fetch
    always_ff @(posedge clk) begin
        if (reset)
            r_instret <= '0;
        else if (r_state == S_UPC)
            r_instret <= r_instret + CNT_W'(1);
    end

    assign o_instret = r_instret;
`else
`endif

endmodule

// File: tb/tb_sm_ctrl_fsm.sv
// tb_sm_ctrl_fsm: directed scoreboard bench for sm_ctrl_fsm.
// Each stimulus step pushes the control word expected in that cycle; a negedge
// monitor pops and compares. Define SM_CTRL_PERF_EN to also check o_instret.
module tb_sm_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset  = 1'b1;
    logic [2:0] opcode = '0;
    logic [1:0] op     = '0;
    logic [2:0] cond   = '0;
    logic       zFlag  = 1'b0;
    logic       nFlag  = 1'b0;
    logic       vFlag  = 1'b0;
    logic       memRdy = 1'b0;

    logic       loada, loadb, loadc, loads, asel, bsel, write;
    logic [3:0] nsel, vsel;
    logic       loadIr, loadPc, resetPc, loadAddr, addrSel;
    logic [1:0] pcSel, memCmd;
    logic       halted, fault;
`ifdef SM_CTRL_PERF_EN
    logic [31:0] instret;
`endif

    sm_ctrl_fsm #(.WAIT_MAX(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_opcode   (opcode),
        .i_op       (op),
        .i_cond     (cond),
        .i_Z        (zFlag),
        .i_N        (nFlag),
        .i_V        (vFlag),
        .i_mem_rdy  (memRdy),
        .o_loada    (loada),
        .o_loadb    (loadb),
        .o_loadc    (loadc),
        .o_loads    (loads),
        .o_asel     (asel),
        .o_bsel     (bsel),
        .o_write    (write),
        .o_nsel     (nsel),
        .o_vsel     (vsel),
        .o_load_ir  (loadIr),
        .o_load_pc  (loadPc),
        .o_reset_pc (resetPc),
        .o_load_addr(loadAddr),
        .o_addr_sel (addrSel),
        .o_pc_sel   (pcSel),
        .o_mem_cmd  (memCmd),
        .o_halted   (halted),
        .o_fault    (fault)
`ifdef SM_CTRL_PERF_EN
        ,.o_instret (instret)
`endif
    );

    logic [25:0] actWord;
    assign actWord = {loada, loadb, loadc, loads, asel, bsel, write, nsel, vsel,
                      loadIr, loadPc, resetPc, loadAddr, addrSel, pcSel, memCmd, halted, fault};

    localparam logic [25:0] F_LOADA   = 26'b1 << 25;
    localparam logic [25:0] F_LOADB   = 26'b1 << 24;
    localparam logic [25:0] F_LOADC   = 26'b1 << 23;
    localparam logic [25:0] F_LOADS   = 26'b1 << 22;
    localparam logic [25:0] F_ASEL    = 26'b1 << 21;
    localparam logic [25:0] F_BSEL    = 26'b1 << 20;
    localparam logic [25:0] F_WRITE   = 26'b1 << 19;
    localparam logic [25:0] F_N_R7    = 26'b1000 << 15;
    localparam logic [25:0] F_N_RN    = 26'b0100 << 15;
    localparam logic [25:0] F_N_RD    = 26'b0010 << 15;
    localparam logic [25:0] F_N_RM    = 26'b0001 << 15;
    localparam logic [25:0] F_V_C     = 26'b0001 << 11;
    localparam logic [25:0] F_V_PC    = 26'b0010 << 11;
    localparam logic [25:0] F_V_IMM   = 26'b0100 << 11;
    localparam logic [25:0] F_V_MD    = 26'b1000 << 11;
    localparam logic [25:0] F_LOADIR  = 26'b1 << 10;
    localparam logic [25:0] F_LOADPC  = 26'b1 << 9;
    localparam logic [25:0] F_RESETPC = 26'b1 << 8;
    localparam logic [25:0] F_LDADDR  = 26'b1 << 7;
    localparam logic [25:0] F_ADDRSEL = 26'b1 << 6;
    localparam logic [25:0] F_PC_REL  = 26'b01 << 4;
    localparam logic [25:0] F_PC_DP   = 26'b10 << 4;
    localparam logic [25:0] F_RD      = 26'b01 << 2;
    localparam logic [25:0] F_WR      = 26'b10 << 2;
    localparam logic [25:0] F_HALT    = 26'b1 << 1;
    localparam logic [25:0] F_FAULT   = 26'b1;

    localparam logic [25:0] E_RST    = F_LOADPC | F_RESETPC;
    localparam logic [25:0] E_IFREQ  = F_RD | F_ADDRSEL;
    localparam logic [25:0] E_IFLD   = F_LOADIR | F_RD | F_ADDRSEL;
    localparam logic [25:0] E_UPC    = F_LOADPC;
    localparam logic [25:0] E_DEC    = 26'b0;
    localparam logic [25:0] E_MOVI   = F_N_RN | F_V_IMM | F_WRITE;
    localparam logic [25:0] E_GETA   = F_N_RN | F_LOADA;
    localparam logic [25:0] E_GETB   = F_N_RM | F_LOADB;
    localparam logic [25:0] E_ALU    = F_LOADC | F_LOADS;
    localparam logic [25:0] E_WREG   = F_N_RD | F_V_C | F_WRITE;
    localparam logic [25:0] E_MOVC   = F_ASEL | F_LOADC;
    localparam logic [25:0] E_ADD5   = F_BSEL | F_LOADC;
    localparam logic [25:0] E_LDADDR = F_LDADDR;
    localparam logic [25:0] E_LDREQ  = F_RD;
    localparam logic [25:0] E_LDWB   = F_RD | F_N_RD | F_V_MD | F_WRITE;
    localparam logic [25:0] E_STADDR = F_LDADDR | F_N_RD | F_LOADB;
    localparam logic [25:0] E_STREQ  = F_WR;
    localparam logic [25:0] E_BR_T   = F_LOADPC | F_PC_REL;
    localparam logic [25:0] E_BR_N   = 26'b0;
    localparam logic [25:0] E_BL     = F_N_R7 | F_V_PC | F_WRITE | F_LOADPC | F_PC_REL;
    localparam logic [25:0] E_BXB    = F_N_RD | F_LOADB;
    localparam logic [25:0] E_BXPC   = F_LOADPC | F_PC_DP;
    localparam logic [25:0] E_BLX    = F_N_R7 | F_V_PC | F_WRITE;
    localparam logic [25:0] E_HALT   = F_HALT;
    localparam logic [25:0] E_FAULT  = F_FAULT;

    // Instruction fields {opcode, op, cond}
    localparam logic [7:0] I_MOVI = 8'b110_10_000;
    localparam logic [7:0] I_ADD  = 8'b101_00_000;
    localparam logic [7:0] I_CMP  = 8'b101_01_000;
    localparam logic [7:0] I_MOV  = 8'b110_00_000;
    localparam logic [7:0] I_LDR  = 8'b011_00_000;
    localparam logic [7:0] I_STR  = 8'b100_00_000;
    localparam logic [7:0] I_BL   = 8'b010_11_000;
    localparam logic [7:0] I_BX   = 8'b010_00_000;
    localparam logic [7:0] I_BLX  = 8'b010_10_011;
    localparam logic [7:0] I_HALT = 8'b111_01_000;
    localparam logic [7:0] I_UNDF = 8'b000_00_000;

    typedef struct {
        logic [25:0] exp;
        int          expInst;
        string       name;
    } exp_t;

    exp_t        sbQueue[$];
    int          errors    = 0;
    int          checks    = 0;
    int          modelInst = 0;
    logic [7:0]  curIr     = '0;
    logic [2:0]  curZnv    = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expected control word per cycle, compared away from the clock edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput(e.name, {6'b0, actWord}, {6'b0, e.exp});
`ifdef SM_CTRL_PERF_EN
            if (e.expInst >= 0)
                checkOutput({e.name, "_instret"}, instret, 32'(e.expInst));
`endif
        end
    end

    task automatic applyStimulus(input logic rst, input logic rdy, input logic [25:0] exp,
                                 input string name, input int expInst = -1);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        memRdy = rdy;
        {opcode, op, cond}    = curIr;
        {zFlag, nFlag, vFlag} = curZnv;
        e.exp     = exp;
        e.expInst = expInst;
        e.name    = name;
        sbQueue.push_back(e);
    endtask

    task automatic fetchDec(input logic [7:0] ir, input logic [2:0] znv, input string tag);
        curIr  = ir;
        curZnv = znv;
        applyStimulus(1'b0, 1'b1, E_IFREQ, {tag, "_ifreq"});
        applyStimulus(1'b0, 1'b1, E_IFLD,  {tag, "_ifld"});
        applyStimulus(1'b0, 1'b1, E_UPC,   {tag, "_upc"});
        modelInst++;
        applyStimulus(1'b0, 1'b1, E_DEC,   {tag, "_dec"}, modelInst);
    endtask

    task automatic doReset(input string tag, input logic [25:0] expNow, input logic rdy);
        applyStimulus(1'b1, rdy, expNow, {tag, "_assert"});
        modelInst = 0;
        applyStimulus(1'b0, 1'b1, E_RST, {tag, "_rst"}, 0);
    endtask

    task automatic waitSteps(input int n, input logic [25:0] exp, input string name);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, exp, name);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b1, E_RST, "reset_state", 0);

        fetchDec(I_MOVI, 3'b000, "movi");
        applyStimulus(1'b0, 1'b1, E_MOVI, "movi_exec");

        fetchDec(I_ADD, 3'b000, "add");
        applyStimulus(1'b0, 1'b1, E_GETA, "add_geta");
        applyStimulus(1'b0, 1'b1, E_GETB, "add_getb");
        applyStimulus(1'b0, 1'b1, E_ALU,  "add_alu");
        applyStimulus(1'b0, 1'b1, E_WREG, "add_wreg");

        fetchDec(I_CMP, 3'b000, "cmp");
        applyStimulus(1'b0, 1'b1, E_GETA, "cmp_geta");
        applyStimulus(1'b0, 1'b1, E_GETB, "cmp_getb");
        applyStimulus(1'b0, 1'b1, E_ALU,  "cmp_alu");

        fetchDec(I_MOV, 3'b000, "mov");
        applyStimulus(1'b0, 1'b1, E_GETB, "mov_b");
        applyStimulus(1'b0, 1'b1, E_MOVC, "mov_c");
        applyStimulus(1'b0, 1'b1, E_WREG, "mov_wreg");

        fetchDec(I_LDR, 3'b000, "ldr");
        applyStimulus(1'b0, 1'b1, E_GETA,   "ldr_a");
        applyStimulus(1'b0, 1'b1, E_ADD5,   "ldr_add");
        applyStimulus(1'b0, 1'b1, E_LDADDR, "ldr_addr");
        waitSteps(3, E_LDREQ, "ldr_req_wait");
        applyStimulus(1'b0, 1'b1, E_LDREQ,  "ldr_req_rdy");
        applyStimulus(1'b0, 1'b1, E_LDWB,   "ldr_wb");

        fetchDec(I_STR, 3'b000, "str");
        applyStimulus(1'b0, 1'b1, E_GETA,   "str_a");
        applyStimulus(1'b0, 1'b1, E_ADD5,   "str_add");
        applyStimulus(1'b0, 1'b1, E_STADDR, "str_addr");
        applyStimulus(1'b0, 1'b1, E_MOVC,   "str_c");
        applyStimulus(1'b0, 1'b0, E_STREQ,  "str_req_wait");
        applyStimulus(1'b0, 1'b1, E_STREQ,  "str_req_rdy");

        // Branch conditions, flags given as {Z,N,V}
        fetchDec(8'b001_00_001, 3'b000, "br_eq_z0");
        applyStimulus(1'b0, 1'b1, E_BR_N, "br_eq_z0_exec");
        fetchDec(8'b001_00_001, 3'b100, "br_eq_z1");
        applyStimulus(1'b0, 1'b1, E_BR_T, "br_eq_z1_exec");
        fetchDec(8'b001_00_010, 3'b100, "br_ne_z1");
        applyStimulus(1'b0, 1'b1, E_BR_N, "br_ne_z1_exec");
        fetchDec(8'b001_00_011, 3'b010, "br_lt_n1");
        applyStimulus(1'b0, 1'b1, E_BR_T, "br_lt_n1_exec");
        fetchDec(8'b001_00_011, 3'b011, "br_lt_nv");
        applyStimulus(1'b0, 1'b1, E_BR_N, "br_lt_nv_exec");
        fetchDec(8'b001_00_100, 3'b000, "br_le_0");
        applyStimulus(1'b0, 1'b1, E_BR_N, "br_le_0_exec");
        fetchDec(8'b001_00_100, 3'b111, "br_le_z");
        applyStimulus(1'b0, 1'b1, E_BR_T, "br_le_z_exec");
        fetchDec(8'b001_00_000, 3'b000, "br_al");
        applyStimulus(1'b0, 1'b1, E_BR_T, "br_al_exec");

        fetchDec(I_BL, 3'b000, "bl");
        applyStimulus(1'b0, 1'b1, E_BL, "bl_exec");

        fetchDec(I_BX, 3'b000, "bx");
        applyStimulus(1'b0, 1'b1, E_BXB,  "bx_b");
        applyStimulus(1'b0, 1'b1, E_MOVC, "bx_c");
        applyStimulus(1'b0, 1'b1, E_BXPC, "bx_pc");

        fetchDec(I_BLX, 3'b000, "blx");
        applyStimulus(1'b0, 1'b1, E_BLX,  "blx_link");
        applyStimulus(1'b0, 1'b1, E_BXB,  "blx_b");
        applyStimulus(1'b0, 1'b1, E_MOVC, "blx_c");
        applyStimulus(1'b0, 1'b1, E_BXPC, "blx_pc");

        // mem_rdy arriving on the last allowed wait cycle still proceeds
        waitSteps(14, E_IFREQ, "prio_wait");
        fetchDec(I_MOVI, 3'b000, "prio");
        applyStimulus(1'b0, 1'b1, E_MOVI, "prio_movi");

        // Reset mid-wait must clear the wait counter
        waitSteps(10, E_IFREQ, "midrst_wait");
        doReset("midrst", E_IFREQ, 1'b0);
        waitSteps(14, E_IFREQ, "midrst_rewait");
        fetchDec(I_MOVI, 3'b000, "midrst_after");
        applyStimulus(1'b0, 1'b1, E_MOVI, "midrst_movi");

        // Stuck memory times out into FAULT
        waitSteps(15, E_IFREQ, "timeout_wait");
        applyStimulus(1'b0, 1'b1, E_FAULT, "timeout_fault");
        applyStimulus(1'b0, 1'b1, E_FAULT, "fault_hold");
        doReset("timeout", E_FAULT, 1'b1);

        fetchDec(8'b001_00_110, 3'b100, "br_bad");
        applyStimulus(1'b0, 1'b1, E_BR_N,  "br_bad_exec");
        applyStimulus(1'b0, 1'b1, E_FAULT, "br_bad_fault");
        doReset("br_bad", E_FAULT, 1'b1);

        fetchDec(I_UNDF, 3'b000, "undef");
        applyStimulus(1'b0, 1'b1, E_FAULT, "undef_fault");
        doReset("undef", E_FAULT, 1'b1);

        fetchDec(I_HALT, 3'b000, "halt");
        applyStimulus(1'b0, 1'b1, E_HALT, "halt_exec");
        applyStimulus(1'b0, 1'b0, E_HALT, "halt_hold");
        doReset("halt", E_HALT, 1'b1);
        applyStimulus(1'b0, 1'b1, E_IFREQ, "final_ifreq");

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQueue.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
